game_flow_ctrl: RTL and testbench

Match sequencer for the air-hockey game. It samples puck position once per frame and detects goals against the drawn goal mouths. It keeps both scores and drives freeze/re-serve controls to the puck physics and the score/overlay draw stages. It sits beside the draw pipeline, clocked by the pixel clock, and consumes the pipeline's vsync.

---
 rtl/game_flow_if.sv | 28 ++
 rtl/game_flow_ctrl.sv | 164 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/game_flow_if.sv
// Signal bundle between the frame-timing/puck-physics side and the match sequencer.
// No valid/ready handshake: inputs are qualified only by the vsync frame tick.
interface game_flow_if;
  logic        vsync_in;
  logic        start_in;
  logic [11:0] puck_x_in;
  logic [11:0] puck_y_in;
  logic [2:0]  state_out;
  logic [3:0]  score_left_out;
  logic [3:0]  score_right_out;
  logic        puck_freeze_out;
  logic        puck_reset_out;
  logic        serve_side_out;
  logic [1:0]  winner_out;
  logic        goal_pulse_out;

  modport master (
    output vsync_in, start_in, puck_x_in, puck_y_in,
    input  state_out, score_left_out, score_right_out, puck_freeze_out,
    input  puck_reset_out, serve_side_out, winner_out, goal_pulse_out
  );

  modport slave (
    input  vsync_in, start_in, puck_x_in, puck_y_in,
    output state_out, score_left_out, score_right_out, puck_freeze_out,
    output puck_reset_out, serve_side_out, winner_out, goal_pulse_out
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Air-hockey match sequencer: per-frame goal detection, scoring, serve/freeze control.
// Optional macro GOAL_DEBOUNCE_EN: a goal needs the same net condition on two consecutive PLAY ticks.
module game_flow_ctrl #(
  parameter int GOAL_Y_TOP   = 258,
  parameter int GOAL_Y_BOT   = 458,
  parameter int GOAL_X_LEFT  = 39,
  parameter int GOAL_X_RIGHT = 984,
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 120
) (
  input  logic        clk_in,
  input  logic        rst,
  game_flow_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE      = 3'd1,
    PLAY       = 3'd2,
    GOAL_PAUSE = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  localparam logic [11:0] Y_TOP      = 12'(GOAL_Y_TOP);
  localparam logic [11:0] Y_BOT      = 12'(GOAL_Y_BOT);
  localparam logic [11:0] X_LEFT     = 12'(GOAL_X_LEFT);
  localparam logic [11:0] X_RIGHT    = 12'(GOAL_X_RIGHT);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [7:0]  PAUSE_LOAD = 8'(PAUSE_FRAMES - 1);

  state_t      state;
  logic [3:0]  score_l, score_r;
  logic        freeze, puck_reset, serve_side, goal_pulse;
  logic [1:0]  winner;
  logic [7:0]  pause_cnt;
  logic        vsync_q;
  logic        armed;
  logic        tick;
  logic        in_mouth, goal_l_raw, goal_r_raw, goal_l, goal_r;
  logic [3:0]  score_l_inc, score_r_inc;

  // armed blocks a false tick when vsync is already high as reset releases
  assign tick        = bus.vsync_in & ~vsync_q & armed;
  assign in_mouth    = (bus.puck_y_in >= Y_TOP) && (bus.puck_y_in <= Y_BOT);
  assign goal_l_raw  = in_mouth && (bus.puck_x_in <= X_LEFT);
  assign goal_r_raw  = in_mouth && (bus.puck_x_in >= X_RIGHT);
  assign score_l_inc = score_l + 4'd1;
  assign score_r_inc = score_r + 4'd1;

`ifdef GOAL_DEBOUNCE_EN
  logic hist_l, hist_r;
  assign goal_l = goal_l_raw & hist_l;
  assign goal_r = goal_r_raw & hist_r;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hist_l <= 1'b0;
      hist_r <= 1'b0;
    end else if (tick) begin
      if (state == PLAY && !goal_l && !goal_r) begin
        hist_l <= goal_l_raw;
        hist_r <= goal_r_raw;
      end else begin
        hist_l <= 1'b0;
        hist_r <= 1'b0;
      end
    end
  end
`else
  assign goal_l = goal_l_raw;
  assign goal_r = goal_r_raw;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      score_l    <= 4'd0;
      score_r    <= 4'd0;
      freeze     <= 1'b1;
      puck_reset <= 1'b0;
      serve_side <= 1'b0;
      winner     <= 2'd0;
      goal_pulse <= 1'b0;
      pause_cnt  <= 8'd0;
      vsync_q    <= 1'b0;
      armed      <= 1'b0;
    end else begin
      vsync_q    <= bus.vsync_in;
      puck_reset <= 1'b0;
      goal_pulse <= 1'b0;
      if (!bus.vsync_in) armed <= 1'b1;
      if (tick) begin
        case (state)
          IDLE, GAME_OVER: begin
            freeze <= 1'b1;
            if (bus.start_in) begin
              state      <= SERVE;
              score_l    <= 4'd0;
              score_r    <= 4'd0;
              winner     <= 2'd0;
              puck_reset <= 1'b1;
            end
          end
          SERVE: begin
            state  <= PLAY;
            freeze <= 1'b0;
          end
          PLAY: begin
            freeze <= 1'b0;
            // left-net goal has priority if both conditions ever coincide
            if (goal_l) begin
              score_r    <= score_r_inc;
              goal_pulse <= 1'b1;
              serve_side <= 1'b0;
              freeze     <= 1'b1;
              if (score_r_inc == WIN) begin
                state  <= GAME_OVER;
                winner <= 2'd2;
              end else begin
                state     <= GOAL_PAUSE;
                pause_cnt <= PAUSE_LOAD;
              end
            end else if (goal_r) begin
              score_l    <= score_l_inc;
              goal_pulse <= 1'b1;
              serve_side <= 1'b1;
              freeze     <= 1'b1;
              if (score_l_inc == WIN) begin
                state  <= GAME_OVER;
                winner <= 2'd1;
              end else begin
                state     <= GOAL_PAUSE;
                pause_cnt <= PAUSE_LOAD;
              end
            end
          end
          GOAL_PAUSE: begin
            freeze <= 1'b1;
            if (pause_cnt == 8'd0) begin
              puck_reset <= 1'b1;
              state      <= SERVE;
            end else begin
              pause_cnt <= pause_cnt - 8'd1;
            end
          end
          default: begin
            state  <= IDLE;
            freeze <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.state_out       = state;
  assign bus.score_left_out  = score_l;
  assign bus.score_right_out = score_r;
  assign bus.puck_freeze_out = freeze;
  assign bus.puck_reset_out  = puck_reset;
  assign bus.serve_side_out  = serve_side;
  assign bus.winner_out      = winner;
  assign bus.goal_pulse_out  = goal_pulse;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: vector table for single-frame behaviour,
// hand-written sequences for pause length, match end, restart and mid-match reset.
module tb_game_flow_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_in = ~clk_in;

  game_flow_if bus();

  game_flow_ctrl dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        s;
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  st;
    logic [3:0]  l;
    logic [3:0]  r;
    logic        fr;
    logic        pr;
    logic        gp;
    logic        side;
    logic [1:0]  win;
  } vec_t;

  vec_t tbl[9];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] st, input logic [3:0] l, r,
                         input logic fr, pr, gp, side, input logic [1:0] win);
    chk({tag, ".state"},  32'(bus.state_out),       32'(st));
    chk({tag, ".score_l"}, 32'(bus.score_left_out), 32'(l));
    chk({tag, ".score_r"}, 32'(bus.score_right_out), 32'(r));
    chk({tag, ".freeze"}, 32'(bus.puck_freeze_out), 32'(fr));
    chk({tag, ".preset"}, 32'(bus.puck_reset_out),  32'(pr));
    chk({tag, ".gpulse"}, 32'(bus.goal_pulse_out),  32'(gp));
    chk({tag, ".side"},   32'(bus.serve_side_out),  32'(side));
    chk({tag, ".winner"}, 32'(bus.winner_out),      32'(win));
  endtask

  // one frame: raise vsync for one clock; returns on the negedge after the tick edge
  task automatic tick(input logic s, input logic [11:0] x, y);
    @(negedge clk_in);
    bus.start_in  = s;
    bus.puck_x_in = x;
    bus.puck_y_in = y;
    bus.vsync_in  = 1'b1;
    @(negedge clk_in);
    bus.vsync_in  = 1'b0;
  endtask

  task automatic pulses_drop(input string tag);
    @(negedge clk_in);
    chk({tag, ".preset_drop"}, 32'(bus.puck_reset_out), 32'd0);
    chk({tag, ".gpulse_drop"}, 32'(bus.goal_pulse_out), 32'd0);
  endtask

  task automatic goal_tick(input string tag, input logic [11:0] x, y, input logic [2:0] st,
                           input logic [3:0] l, r, input logic side, input logic [1:0] win);
`ifdef GOAL_DEBOUNCE_EN
    tick(1'b0, x, y);
    chk_out({tag, ".first"}, S_PLAY, side ? l - 4'd1 : l, side ? r : r - 4'd1,
            1'b0, 1'b0, 1'b0, bus.serve_side_out, 2'd0);
`endif
    tick(1'b0, x, y);
    chk_out(tag, st, l, r, 1'b1, 1'b0, 1'b1, side, win);
    pulses_drop(tag);
  endtask

  task automatic do_pause(input logic [3:0] l, r, input logic side);
    for (int i = 0; i < 119; i++) begin
      tick(1'b0, 12'd20, 12'd300);
      chk_out("pause", S_PAUSE, l, r, 1'b1, 1'b0, 1'b0, side, 2'd0);
    end
    tick(1'b0, 12'd20, 12'd300);
    chk_out("reserve", S_SERVE, l, r, 1'b1, 1'b1, 1'b0, side, 2'd0);
    pulses_drop("reserve");
    tick(1'b0, 12'd500, 12'd300);
    chk_out("replay", S_PLAY, l, r, 1'b0, 1'b0, 1'b0, side, 2'd0);
  endtask

  initial begin
    bus.vsync_in  = 1'b0;
    bus.start_in  = 1'b0;
    bus.puck_x_in = 12'd500;
    bus.puck_y_in = 12'd300;

    //        s     x       y       state    l     r     fr    pr    gp    side  win
    tbl[0] = '{1'b0, 12'd500, 12'd300, S_IDLE,  4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1] = '{1'b1, 12'd500, 12'd300, S_SERVE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 12'd20,  12'd300, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b0, 12'd20,  12'd200, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{1'b0, 12'd500, 12'd300, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{1'b1, 12'd40,  12'd300, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[6] = '{1'b0, 12'd983, 12'd458, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[7] = '{1'b0, 12'd39,  12'd257, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[8] = '{1'b0, 12'd984, 12'd459, S_PLAY,  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

    repeat (3) @(negedge clk_in);
    chk_out("reset", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].s, tbl[i].x, tbl[i].y);
      chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].l, tbl[i].r, tbl[i].fr,
              tbl[i].pr, tbl[i].gp, tbl[i].side, tbl[i].win);
    end

`ifdef GOAL_DEBOUNCE_EN
    tick(1'b0, 12'd20, 12'd300);
    chk_out("deb_single", S_PLAY, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1'b0, 12'd500, 12'd300);
    chk_out("deb_clear", S_PLAY, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

    // right player scores at the inclusive mouth corner
    goal_tick("goal_r1", 12'd39, 12'd458, S_PAUSE, 4'd0, 4'd1, 1'b0, 2'd0);
    do_pause(4'd0, 4'd1, 1'b0);

    // left player runs to WIN_SCORE
    for (int g = 1; g <= 7; g++) begin
      if (g < 7) begin
        goal_tick($sformatf("goal_l%0d", g), (g % 2) ? 12'd1000 : 12'd984,
                  (g % 2) ? 12'd350 : 12'd258, S_PAUSE, 4'(g), 4'd1, 1'b1, 2'd0);
        do_pause(4'(g), 4'd1, 1'b1);
      end else begin
        goal_tick("goal_win", 12'd1000, 12'd350, S_OVER, 4'd7, 4'd1, 1'b1, 2'd1);
      end
    end

    tick(1'b0, 12'd20, 12'd300);
    chk_out("over_hold_a", S_OVER, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    tick(1'b0, 12'd1000, 12'd350);
    chk_out("over_hold_b", S_OVER, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    tick(1'b1, 12'd500, 12'd300);
    chk_out("restart", S_SERVE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0);
    pulses_drop("restart");
    tick(1'b0, 12'd500, 12'd300);
    chk_out("restart_play", S_PLAY, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);

    // goal, then reset with the pause counter at 50
    goal_tick("goal_pre_rst", 12'd1000, 12'd300, S_PAUSE, 4'd1, 4'd0, 1'b1, 2'd0);
    for (int i = 0; i < 69; i++) tick(1'b0, 12'd500, 12'd300);
    chk("pause_mid.state", 32'(bus.state_out), 32'(S_PAUSE));
    @(negedge clk_in);
    rst          = 1'b1;
    bus.vsync_in = 1'b1;
    bus.start_in = 1'b1;
    @(negedge clk_in);
    chk_out("mid_rst", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk_in);
    rst = 1'b0;
    // vsync already high at release must not count as a frame tick
    repeat (4) @(negedge clk_in);
    chk_out("no_false_tick", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    bus.vsync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 12'd500, 12'd300);
      chk_out("idle_stay", S_IDLE, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    tick(1'b1, 12'd500, 12'd300);
    chk_out("start_after_rst", S_SERVE, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
